avalon_master_arbiter: RTL and testbench
========================================

Name: avalon_master_arbiter

Overview:
- Parametrised N-port Avalon-MM master arbiter; merges NUM_MASTERS local masters onto one core Avalon master port.
- Replaces the fixed two-port write-priority mux with:
  - round-robin arbitration;
  - lock-held grants;
  - pipelined reads, with readdatavalid routed back through an in-order response-ID FIFO.
- Sits between the DMA/read/write engines and the HPS/SDRAM bridge master.

Parameters:
- NUM_MASTERS, 2, number of local masters (2..8).
- ADDR_W, 64, address width.
- DATA_W, 512, data width; BE_W = DATA_W/8.
- MAX_PENDING, 8, max outstanding reads (power of 2, ≥2).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- m_address  in  NUM_MASTERS*ADDR_W  per-master address, master i at slice i.
- m_read  in  NUM_MASTERS  read request.
- m_write  in  NUM_MASTERS  write request.
- m_byteenable  in  NUM_MASTERS*BE_W  byte enables.
- m_writedata  in  NUM_MASTERS*DATA_W  write data.
- m_lock  in  NUM_MASTERS  hold-grant request.
- m_waitrequest  out  NUM_MASTERS  per-master stall.
- m_readdata  out  DATA_W  broadcast read data (= av_readdata).
- m_readdatavalid  out  NUM_MASTERS  per-master read-data strobe.
- av_address  out  ADDR_W.
- av_read  out  1.
- av_write  out  1.
- av_byteenable  out  BE_W.
- av_writedata  out  DATA_W.
- av_lock  out  1.
- av_waitrequest  in  1.
- av_readdata  in  DATA_W.
- av_readdatavalid  in  1.
- pending_cnt  out  clog2(MAX_PENDING)+1  outstanding reads.
- rsp_err  out  1  sticky: readdatavalid with empty ID FIFO.

Behaviour:
- req[i] = m_read[i] | m_write[i].
- read & write both high on one master: write wins, read ignored (protocol violation, not flagged).
- States: IDLE (no held grant), HELD (gnt_id registered).
- IDLE:
  - Winner = first requesting i at or after rr_ptr, cyclic.
  - Winner drives the av_* bus combinationally in the same cycle (zero-cycle latency).
  - No requests → av_read = av_write = 0, av_address/byteenable/writedata = 0.
- Acceptance = (av_read | av_write) & ~av_waitrequest.
- Transitions:
  - IDLE → HELD when the winner's command is not accepted, or is accepted with m_lock high.
  - IDLE stays IDLE when accepted with lock low; rr_ptr <= winner+1 mod NUM_MASTERS.
  - HELD → IDLE on an accepted command with m_lock[gnt_id] low, or on a cycle with req[gnt_id]=0 and m_lock[gnt_id]=0; rr_ptr <= gnt_id+1.
- HELD: only gnt_id drives the bus; arbitration frozen, so address/data stay stable under waitrequest.
- av_lock = m_lock of the selected master.
- m_waitrequest[i]:
  - 1 if i not selected;
  - else av_waitrequest, or (selected read & FIFO full).
- Full blocking: count == MAX_PENDING → av_read forced 0; grant still held. Same-cycle pop does NOT unblock (no bypass). Writes unaffected by full.
- Response FIFO:
  - Accepted read pushes the selected ID.
  - av_readdatavalid pops the head; m_readdatavalid[head] = 1 in that cycle; others 0.
  - Push and pop in the same cycle → count unchanged.
  - Pointers wrap mod MAX_PENDING.
- av_readdatavalid with FIFO empty: no strobe, no pop, rsp_err <= 1 (sticky until rst).
- Ordering: slave responses are in order; writes never enter the FIFO.
- Reset values:
  - m_waitrequest all 1; m_readdatavalid 0.
  - av_read / av_write / av_lock 0; av_* data/address 0.
  - pending_cnt 0, rsp_err 0, rr_ptr 0, state IDLE.
- Reset mid-operation: outstanding IDs discarded. Late responses after rst falls set rsp_err.

Decomposition:
- Package avalon_arb_pkg: clog2 function, ID_W = clog2(NUM_MASTERS), state enum {IDLE, HELD}.
- Sub-module avalon_rsp_fifo: ID FIFO, depth MAX_PENDING, width ID_W, outputs full/empty/count.
- Arbiter FSM and bus mux stay in the top.

Test Plan:
- Reset: rst=1 with all m_read=1 → m_waitrequest=all 1, av_read=0, pending_cnt=0; after release, master 0 is granted first.
- Round-robin: NUM_MASTERS=3, all m_write=1, av_waitrequest=0 → grants 0,1,2,0 on consecutive cycles; av_address follows the granted slice.
- Waitrequest stall: m1 write, av_waitrequest=1 for 3 cycles, m0 also requesting → av_address stays m1's for 4 cycles; m0 is granted the cycle after acceptance.
- Lock: m0 locked, 4 back-to-back writes with m1 requesting → m1 waits until the write with m_lock low is accepted; m1 is granted the next cycle.
- Pipelined reads: m0, m1, m0 reads accepted, then 3 readdatavalids → m_readdatavalid = 01, 10, 01 with av_readdata passed through; pending_cnt 3→0.
- Full / error:
  - MAX_PENDING=2, third read → av_read=0, m_waitrequest=1 until a pop.
  - readdatavalid with pending_cnt=0 → rsp_err=1, no strobe.

Source files
------------

// File: rtl/avalon_arb_pkg.sv
// Shared types and helpers for the Avalon-MM master arbiter.
package avalon_arb_pkg;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = 32'(i + 1);
    end
    return r;
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } arb_state_e;

endpackage

// File: rtl/avalon_rsp_fifo.sv
// In-order FIFO of master IDs for outstanding reads; head tells whose readdata arrives next.
module avalon_rsp_fifo
  import avalon_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_push_id,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_head_id,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [clog2(DEPTH):0]  o_count
);

  localparam int unsigned PTR_W = clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_push    = i_push & ~o_full;
  assign w_pop     = i_pop & ~o_empty;
  assign o_head_id = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_id;
  end

endmodule

// File: rtl/avalon_master_arbiter.sv
// Round-robin N:1 Avalon-MM master arbiter with lock-held grants and pipelined
// reads; read responses are steered back through an in-order ID FIFO.
module avalon_master_arbiter
  import avalon_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned ADDR_W      = 64,
  parameter int unsigned DATA_W      = 512,
  parameter int unsigned MAX_PENDING = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_MASTERS*ADDR_W-1:0]     m_address,
  input  logic [NUM_MASTERS-1:0]            m_read,
  input  logic [NUM_MASTERS-1:0]            m_write,
  input  logic [NUM_MASTERS*(DATA_W/8)-1:0] m_byteenable,
  input  logic [NUM_MASTERS*DATA_W-1:0]     m_writedata,
  input  logic [NUM_MASTERS-1:0]            m_lock,
  output logic [NUM_MASTERS-1:0]            m_waitrequest,
  output logic [DATA_W-1:0]                 m_readdata,
  output logic [NUM_MASTERS-1:0]            m_readdatavalid,
  output logic [ADDR_W-1:0]                 av_address,
  output logic                              av_read,
  output logic                              av_write,
  output logic [DATA_W/8-1:0]               av_byteenable,
  output logic [DATA_W-1:0]                 av_writedata,
  output logic                              av_lock,
  input  logic                              av_waitrequest,
  input  logic [DATA_W-1:0]                 av_readdata,
  input  logic                              av_readdatavalid,
  output logic [clog2(MAX_PENDING):0]       pending_cnt,
  output logic                              rsp_err
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned ID_W  = clog2(NUM_MASTERS);
  localparam int unsigned SUM_W = ID_W + 1;

  arb_state_e       r_state;
  logic [ID_W-1:0]  r_gnt_id;
  logic [ID_W-1:0]  r_rr_ptr;
  logic             r_rsp_err;

  logic [NUM_MASTERS-1:0] w_req;
  logic                   w_win_vld;
  logic [ID_W-1:0]        w_win_id;
  logic                   w_sel_vld;
  logic [ID_W-1:0]        w_sel_id;
  logic                   w_sel_req;
  logic                   w_sel_rd;
  logic                   w_sel_wr;
  logic                   w_accept;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;
  logic [ID_W-1:0]        w_head_id;

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    return (id == ID_W'(NUM_MASTERS - 1)) ? '0 : id + ID_W'(1);
  endfunction

  assign w_req = m_read | m_write;

  // First requester at or after the round-robin pointer, cyclic.
  always_comb begin
    logic [SUM_W-1:0] w_sum;
    w_win_vld = 1'b0;
    w_win_id  = '0;
    w_sum     = '0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      w_sum = {1'b0, r_rr_ptr} + SUM_W'(k);
      if (w_sum >= SUM_W'(NUM_MASTERS)) w_sum = w_sum - SUM_W'(NUM_MASTERS);
      if (!w_win_vld && w_req[w_sum[ID_W-1:0]]) begin
        w_win_vld = 1'b1;
        w_win_id  = w_sum[ID_W-1:0];
      end
    end
  end

  // A held grant freezes arbitration so the bus stays stable under waitrequest.
  always_comb begin
    w_sel_vld = 1'b0;
    w_sel_id  = '0;
    if (!rst) begin
      if (r_state == HELD) begin
        w_sel_vld = 1'b1;
        w_sel_id  = r_gnt_id;
      end else begin
        w_sel_vld = w_win_vld;
        w_sel_id  = w_win_id;
      end
    end
  end

  assign w_sel_req = w_sel_vld & w_req[w_sel_id];
  assign w_sel_wr  = w_sel_vld & m_write[w_sel_id];
  assign w_sel_rd  = w_sel_vld & m_read[w_sel_id] & ~m_write[w_sel_id];

  assign av_read       = w_sel_rd & ~w_fifo_full;
  assign av_write      = w_sel_wr;
  assign av_lock       = w_sel_vld & m_lock[w_sel_id];
  assign av_address    = w_sel_req ? m_address[32'(w_sel_id)*ADDR_W +: ADDR_W] : '0;
  assign av_writedata  = w_sel_req ? m_writedata[32'(w_sel_id)*DATA_W +: DATA_W] : '0;
  assign av_byteenable = w_sel_req ? m_byteenable[32'(w_sel_id)*BE_W +: BE_W] : '0;
  assign m_readdata    = av_readdata;

  assign w_accept = (av_read | av_write) & ~av_waitrequest;
  assign w_push   = av_read & ~av_waitrequest;
  assign w_pop    = av_readdatavalid & ~w_fifo_empty;

  always_comb begin
    m_waitrequest = '1;
    if (w_sel_vld) m_waitrequest[w_sel_id] = av_waitrequest | (w_sel_rd & w_fifo_full);
  end

  always_comb begin
    m_readdatavalid = '0;
    if (w_pop) m_readdatavalid[w_head_id] = 1'b1;
  end

  avalon_rsp_fifo #(
    .DEPTH (MAX_PENDING),
    .WIDTH (ID_W)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_push),
    .i_push_id (w_sel_id),
    .i_pop     (w_pop),
    .o_head_id (w_head_id),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty),
    .o_count   (pending_cnt)
  );

  // Grant FSM; the pointer only advances when a grant is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_gnt_id  <= '0;
      r_rr_ptr  <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      if (av_readdatavalid && w_fifo_empty) r_rsp_err <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_win_vld) begin
            if (!w_accept || m_lock[w_win_id]) begin
              r_state  <= HELD;
              r_gnt_id <= w_win_id;
            end else begin
              r_rr_ptr <= next_id(w_win_id);
            end
          end
        end
        HELD: begin
          if ((w_accept && !m_lock[r_gnt_id]) ||
              (!w_req[r_gnt_id] && !m_lock[r_gnt_id])) begin
            r_state  <= IDLE;
            r_rr_ptr <= next_id(r_gnt_id);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rsp_err = r_rsp_err;

endmodule

// File: tb/tb_avalon_master_arbiter.sv
// Directed per-cycle vector bench for avalon_master_arbiter (3 masters, 2 outstanding reads).
module tb_avalon_master_arbiter;

  localparam int unsigned N     = 3;
  localparam int unsigned AW    = 16;
  localparam int unsigned DW    = 32;
  localparam int unsigned BW    = DW / 8;
  localparam int unsigned CNT_W = 2;

  logic            clk;
  logic            rst;
  logic [N*AW-1:0] m_address;
  logic [N-1:0]    m_read;
  logic [N-1:0]    m_write;
  logic [N*BW-1:0] m_byteenable;
  logic [N*DW-1:0] m_writedata;
  logic [N-1:0]    m_lock;
  logic [N-1:0]    m_waitrequest;
  logic [DW-1:0]   m_readdata;
  logic [N-1:0]    m_readdatavalid;
  logic [AW-1:0]   av_address;
  logic            av_read;
  logic            av_write;
  logic [BW-1:0]   av_byteenable;
  logic [DW-1:0]   av_writedata;
  logic            av_lock;
  logic            av_waitrequest;
  logic [DW-1:0]   av_readdata;
  logic            av_readdatavalid;
  logic [CNT_W-1:0] pending_cnt;
  logic            rsp_err;

  int n_vec;
  int n_bad;

  avalon_master_arbiter #(
    .NUM_MASTERS (N),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .MAX_PENDING (2)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .m_address        (m_address),
    .m_read           (m_read),
    .m_write          (m_write),
    .m_byteenable     (m_byteenable),
    .m_writedata      (m_writedata),
    .m_lock           (m_lock),
    .m_waitrequest    (m_waitrequest),
    .m_readdata       (m_readdata),
    .m_readdatavalid  (m_readdatavalid),
    .av_address       (av_address),
    .av_read          (av_read),
    .av_write         (av_write),
    .av_byteenable    (av_byteenable),
    .av_writedata     (av_writedata),
    .av_lock          (av_lock),
    .av_waitrequest   (av_waitrequest),
    .av_readdata      (av_readdata),
    .av_readdatavalid (av_readdatavalid),
    .pending_cnt      (pending_cnt),
    .rsp_err          (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [2:0] rd, wr, lk;
    logic       aw, rdv;
    logic       e_rd, e_wr;
    int         e_id;       // master expected on the bus, 3 = bus zeroed
    logic       e_lk;
    logic [2:0] e_mw, e_rv;
    int         e_cnt;
    logic       e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic r, input logic [2:0] rd, wr, lk, input logic aw, rdv,
                             input logic e_rd, e_wr, input int e_id, input logic e_lk,
                             input logic [2:0] e_mw, e_rv, input int e_cnt, input logic e_err);
    vec_t t;
    t.rst = r; t.rd = rd; t.wr = wr; t.lk = lk; t.aw = aw; t.rdv = rdv;
    t.e_rd = e_rd; t.e_wr = e_wr; t.e_id = e_id; t.e_lk = e_lk;
    t.e_mw = e_mw; t.e_rv = e_rv; t.e_cnt = e_cnt; t.e_err = e_err;
    return t;
  endfunction

  task automatic apply(input vec_t t, input int idx);
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic [BW-1:0] eb;
    logic [DW-1:0] rdata;
    bit ok;
    @(negedge clk);
    rdata            = 32'hC0DE_0000 + 32'(idx);
    rst              = t.rst;
    m_read           = t.rd;
    m_write          = t.wr;
    m_lock           = t.lk;
    av_waitrequest   = t.aw;
    av_readdatavalid = t.rdv;
    av_readdata      = rdata;
    #1;
    ea = (t.e_id == 3) ? '0 : 16'hA000 + 16'(t.e_id);
    ed = (t.e_id == 3) ? '0 : 32'hD000_0000 + 32'(t.e_id);
    eb = (t.e_id == 3) ? '0 : 4'(1 << t.e_id);
    ok = (av_read === t.e_rd) && (av_write === t.e_wr) && (av_address === ea) &&
         (av_writedata === ed) && (av_byteenable === eb) && (av_lock === t.e_lk) &&
         (m_waitrequest === t.e_mw) && (m_readdatavalid === t.e_rv) &&
         (m_readdata === rdata) && (pending_cnt === CNT_W'(t.e_cnt)) && (rsp_err === t.e_err);
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL vec%0d: got rd=%b wr=%b addr=%h wd=%h be=%h lk=%b mw=%b rv=%b rdat=%h cnt=%0d err=%b ; want rd=%b wr=%b addr=%h wd=%h be=%h lk=%b mw=%b rv=%b rdat=%h cnt=%0d err=%b",
               idx, av_read, av_write, av_address, av_writedata, av_byteenable, av_lock,
               m_waitrequest, m_readdatavalid, m_readdata, pending_cnt, rsp_err,
               t.e_rd, t.e_wr, ea, ed, eb, t.e_lk, t.e_mw, t.e_rv, rdata, t.e_cnt, t.e_err);
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, got, exp);
    end
  endtask

  initial begin
    n_vec            = 0;
    n_bad            = 0;
    rst              = 1'b1;
    m_address        = {16'hA002, 16'hA001, 16'hA000};
    m_writedata      = {32'hD000_0002, 32'hD000_0001, 32'hD000_0000};
    m_byteenable     = {4'h4, 4'h2, 4'h1};
    m_read           = '0;
    m_write          = '0;
    m_lock           = '0;
    av_waitrequest   = 1'b0;
    av_readdatavalid = 1'b0;
    av_readdata      = '0;

    //             rst  rd      wr      lk      aw  rdv  erd ewr id elk emw     erv     cnt err
    tbl.push_back(v(1, 3'b111, 3'b000, 3'b000, 0, 0,  0, 0, 3, 0, 3'b111, 3'b000, 0, 0)); // 0 reset
    tbl.push_back(v(0, 3'b111, 3'b000, 3'b000, 0, 0,  1, 0, 0, 0, 3'b110, 3'b000, 0, 0)); // 1 m0 first
    tbl.push_back(v(0, 3'b000, 3'b000, 3'b000, 0, 1,  0, 0, 3, 0, 3'b111, 3'b001, 1, 0)); // 2 m0 rdv
    tbl.push_back(v(0, 3'b000, 3'b111, 3'b000, 0, 0,  0, 1, 1, 0, 3'b101, 3'b000, 0, 0)); // 3 rr
    tbl.push_back(v(0, 3'b000, 3'b111, 3'b000, 0, 0,  0, 1, 2, 0, 3'b011, 3'b000, 0, 0));
    tbl.push_back(v(0, 3'b000, 3'b111, 3'b000, 0, 0,  0, 1, 0, 0, 3'b110, 3'b000, 0, 0));
    tbl.push_back(v(0, 3'b000, 3'b111, 3'b000, 0, 0,  0, 1, 1, 0, 3'b101, 3'b000, 0, 0));
    tbl.push_back(v(0, 3'b000, 3'b001, 3'b000, 0, 0,  0, 1, 0, 0, 3'b110, 3'b000, 0, 0)); // 7 rr->1
    tbl.push_back(v(0, 3'b000, 3'b011, 3'b000, 1, 0,  0, 1, 1, 0, 3'b111, 3'b000, 0, 0)); // 8 stall
    tbl.push_back(v(0, 3'b000, 3'b011, 3'b000, 1, 0,  0, 1, 1, 0, 3'b111, 3'b000, 0, 0));
    tbl.push_back(v(0, 3'b000, 3'b011, 3'b000, 1, 0,  0, 1, 1, 0, 3'b111, 3'b000, 0, 0));
    tbl.push_back(v(0, 3'b000, 3'b011, 3'b000, 0, 0,  0, 1, 1, 0, 3'b101, 3'b000, 0, 0)); // 11 accept
    tbl.push_back(v(0, 3'b000, 3'b011, 3'b000, 0, 0,  0, 1, 0, 0, 3'b110, 3'b000, 0, 0)); // 12 m0 next
    tbl.push_back(v(0, 3'b000, 3'b100, 3'b000, 0, 0,  0, 1, 2, 0, 3'b011, 3'b000, 0, 0)); // 13 rr->0
    tbl.push_back(v(0, 3'b000, 3'b011, 3'b001, 0, 0,  0, 1, 0, 1, 3'b110, 3'b000, 0, 0)); // 14 lock
    tbl.push_back(v(0, 3'b000, 3'b011, 3'b001, 0, 0,  0, 1, 0, 1, 3'b110, 3'b000, 0, 0));
    tbl.push_back(v(0, 3'b000, 3'b011, 3'b001, 0, 0,  0, 1, 0, 1, 3'b110, 3'b000, 0, 0));
    tbl.push_back(v(0, 3'b000, 3'b011, 3'b000, 0, 0,  0, 1, 0, 0, 3'b110, 3'b000, 0, 0)); // 17 unlock
    tbl.push_back(v(0, 3'b000, 3'b010, 3'b000, 0, 0,  0, 1, 1, 0, 3'b101, 3'b000, 0, 0)); // 18 m1
    tbl.push_back(v(0, 3'b001, 3'b000, 3'b000, 0, 0,  1, 0, 0, 0, 3'b110, 3'b000, 0, 0)); // 19 rd m0
    tbl.push_back(v(0, 3'b010, 3'b000, 3'b000, 0, 0,  1, 0, 1, 0, 3'b101, 3'b000, 1, 0)); // 20 rd m1
    tbl.push_back(v(0, 3'b001, 3'b000, 3'b000, 0, 1,  0, 0, 0, 0, 3'b111, 3'b001, 2, 0)); // 21 full
    tbl.push_back(v(0, 3'b001, 3'b000, 3'b000, 0, 1,  1, 0, 0, 0, 3'b110, 3'b010, 1, 0)); // 22 push+pop
    tbl.push_back(v(0, 3'b000, 3'b000, 3'b000, 0, 1,  0, 0, 3, 0, 3'b111, 3'b001, 1, 0));
    tbl.push_back(v(0, 3'b000, 3'b000, 3'b000, 0, 1,  0, 0, 3, 0, 3'b111, 3'b000, 0, 0)); // 24 stray rdv
    tbl.push_back(v(0, 3'b000, 3'b000, 3'b000, 0, 0,  0, 0, 3, 0, 3'b111, 3'b000, 0, 1)); // 25 err sticky
    tbl.push_back(v(0, 3'b001, 3'b000, 3'b000, 0, 0,  1, 0, 0, 0, 3'b110, 3'b000, 0, 1));
    tbl.push_back(v(0, 3'b010, 3'b000, 3'b000, 0, 0,  1, 0, 1, 0, 3'b101, 3'b000, 1, 1));
    tbl.push_back(v(0, 3'b000, 3'b100, 3'b000, 0, 0,  0, 1, 2, 0, 3'b011, 3'b000, 2, 1)); // 28 wr at full
    tbl.push_back(v(0, 3'b000, 3'b000, 3'b000, 0, 1,  0, 0, 3, 0, 3'b111, 3'b001, 2, 1));
    tbl.push_back(v(0, 3'b000, 3'b000, 3'b000, 0, 1,  0, 0, 3, 0, 3'b111, 3'b010, 1, 1));
    tbl.push_back(v(0, 3'b001, 3'b000, 3'b000, 0, 0,  1, 0, 0, 0, 3'b110, 3'b000, 0, 1)); // 31 outstanding
    tbl.push_back(v(1, 3'b001, 3'b000, 3'b000, 0, 0,  0, 0, 3, 0, 3'b111, 3'b000, 0, 0)); // 32 mid reset
    tbl.push_back(v(0, 3'b000, 3'b000, 3'b000, 0, 1,  0, 0, 3, 0, 3'b111, 3'b000, 0, 0)); // 33 late rsp
    tbl.push_back(v(0, 3'b000, 3'b110, 3'b000, 0, 0,  0, 1, 1, 0, 3'b101, 3'b000, 0, 1)); // 34 rr reset

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Read stalled under waitrequest: command must hold steady, then respond to m2.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      m_read = 3'b100; m_write = '0; m_lock = '0;
      av_waitrequest = 1'b1; av_readdatavalid = 1'b0;
      #1;
      check("stall_addr", 32'(av_address), 32'hA002);
      check("stall_read", 32'(av_read), 32'd1);
      check("stall_wait", 32'(m_waitrequest), 32'b111);
    end
    @(negedge clk);
    av_waitrequest = 1'b0;
    #1;
    check("accept_wait", 32'(m_waitrequest), 32'b011);
    check("accept_addr", 32'(av_address), 32'hA002);
    @(negedge clk);
    m_read = '0; av_readdatavalid = 1'b1; av_readdata = 32'h1234_5678;
    #1;
    check("rsp_strobe", 32'(m_readdatavalid), 32'b100);
    check("rsp_data", m_readdata, 32'h1234_5678);
    check("rsp_cnt", 32'(pending_cnt), 32'd1);
    @(negedge clk);
    av_readdatavalid = 1'b0;
    #1;
    check("drain_cnt", 32'(pending_cnt), 32'd0);
    check("drain_err", 32'(rsp_err), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
